// File: rtl/calc1_req_scheduler.sv
// Four-port request scheduler sharing one ALU, round-robin grant.
// Define CALC1_SCHED_TIMEOUT_EN to enable the 16-cycle WAIT timeout.
module calc1_req_scheduler (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic        alu_valid,
    output logic [0:3]  alu_cmd,
    output logic [0:31] alu_op1,
    output logic [0:31] alu_op2,
    input  logic        alu_done,
    input  logic        alu_overflow,
    input  logic [0:31] alu_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {SL_FREE, SL_OP2, SL_PEND, SL_BUSY} slot_t;

    state_t      state, state_nxt;
    slot_t       slot  [4];
    logic [3:0]  cmd_q [4];
    logic [31:0] op1_q [4];
    logic [31:0] op2_q [4];
    logic [3:0]  cmd_in  [4];
    logic [31:0] data_in [4];
    logic [1:0]  last, gnt, pick, idx;
    logic        pick_vld;
    logic [1:0]  rcode;
    logic [31:0] rdata;
`ifdef CALC1_SCHED_TIMEOUT_EN
    logic [3:0]  tmo_cnt;
`endif

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    function automatic logic valid_cmd(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    // Search starts one past the last granted port.
    always_comb begin
        pick     = last;
        pick_vld = 1'b0;
        idx      = last;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!pick_vld && slot[idx] == SL_PEND) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (pick_vld)
                    state_nxt = valid_cmd(cmd_q[pick]) ? ISSUE : RESP;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (alu_done)
                    state_nxt = RESP;
`ifdef CALC1_SCHED_TIMEOUT_EN
                else if (tmo_cnt == 4'hF)
                    state_nxt = RESP;
`endif
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                slot[i]  <= SL_FREE;
                cmd_q[i] <= '0;
                op1_q[i] <= '0;
                op2_q[i] <= '0;
            end
            last    <= 2'd3;
            gnt     <= '0;
            alu_cmd <= '0;
            alu_op1 <= '0;
            alu_op2 <= '0;
            rcode   <= '0;
            rdata   <= '0;
`ifdef CALC1_SCHED_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                unique case (slot[i])
                    SL_FREE:
                        if (cmd_in[i] != 4'd0) begin
                            slot[i]  <= SL_OP2;
                            cmd_q[i] <= cmd_in[i];
                            op1_q[i] <= data_in[i];
                        end
                    SL_OP2: begin
                        op2_q[i] <= data_in[i];
                        slot[i]  <= SL_PEND;
                    end
                    default: ;
                endcase
            end
            unique case (state)
                IDLE:
                    if (pick_vld) begin
                        slot[pick] <= SL_BUSY;
                        gnt        <= pick;
                        last       <= pick;
                        alu_cmd    <= cmd_q[pick];
                        alu_op1    <= op1_q[pick];
                        alu_op2    <= op2_q[pick];
                        rcode      <= 2'd2;
                        rdata      <= '0;
                    end
                ISSUE: begin
`ifdef CALC1_SCHED_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (alu_done) begin
                        rcode <= alu_overflow ? 2'd2 : 2'd1;
                        rdata <= alu_overflow ? 32'd0 : alu_result;
                    end
`ifdef CALC1_SCHED_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                        if (tmo_cnt == 4'hF) begin
                            rcode <= 2'd3;
                            rdata <= '0;
                        end
                    end
`endif
                end
                RESP:    slot[gnt] <= SL_FREE;
                default: ;
            endcase
        end
    end

    assign alu_valid = (state == ISSUE);

    always_comb begin
        out_resp1 = '0;
        out_resp2 = '0;
        out_resp3 = '0;
        out_resp4 = '0;
        out_data1 = '0;
        out_data2 = '0;
        out_data3 = '0;
        out_data4 = '0;
        if (state == RESP) begin
            unique case (gnt)
                2'd0: begin out_resp1 = rcode; out_data1 = rdata; end
                2'd1: begin out_resp2 = rcode; out_data2 = rdata; end
                2'd2: begin out_resp3 = rcode; out_data3 = rdata; end
                default: begin out_resp4 = rcode; out_data4 = rdata; end
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_req_scheduler.sv
// Directed bench for calc1_req_scheduler with a simple ALU responder.
// Timeout case runs only when CALC1_SCHED_TIMEOUT_EN is defined.
module tb_calc1_req_scheduler;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic [0:3]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
    logic [0:31] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic [0:1]  out_resp1, out_resp2, out_resp3, out_resp4;
    logic [0:31] out_data1, out_data2, out_data3, out_data4;
    logic        alu_valid;
    logic [0:3]  alu_cmd;
    logic [0:31] alu_op1, alu_op2;
    logic        alu_done, alu_overflow;
    logic [0:31] alu_result;

    logic [3:0]  cmd_v [4];
    logic [31:0] dat_v [4];
    logic [1:0]  resp_w [4];
    logic [31:0] data_w [4];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t0;

    calc1_req_scheduler dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(req1_cmd_in), .req2_cmd_in(req2_cmd_in),
        .req3_cmd_in(req3_cmd_in), .req4_cmd_in(req4_cmd_in),
        .req1_data_in(req1_data_in), .req2_data_in(req2_data_in),
        .req3_data_in(req3_data_in), .req4_data_in(req4_data_in),
        .out_resp1(out_resp1), .out_resp2(out_resp2),
        .out_resp3(out_resp3), .out_resp4(out_resp4),
        .out_data1(out_data1), .out_data2(out_data2),
        .out_data3(out_data3), .out_data4(out_data4),
        .alu_valid(alu_valid), .alu_cmd(alu_cmd),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_done(alu_done), .alu_overflow(alu_overflow),
        .alu_result(alu_result)
    );

    assign req1_cmd_in  = cmd_v[0];
    assign req2_cmd_in  = cmd_v[1];
    assign req3_cmd_in  = cmd_v[2];
    assign req4_cmd_in  = cmd_v[3];
    assign req1_data_in = dat_v[0];
    assign req2_data_in = dat_v[1];
    assign req3_data_in = dat_v[2];
    assign req4_data_in = dat_v[3];
    assign resp_w[0] = out_resp1;
    assign resp_w[1] = out_resp2;
    assign resp_w[2] = out_resp3;
    assign resp_w[3] = out_resp4;
    assign data_w[0] = out_data1;
    assign data_w[1] = out_data2;
    assign data_w[2] = out_data3;
    assign data_w[3] = out_data4;

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    // ALU responder: done arrives alu_lat negedges after the issue strobe.
    int          alu_lat = 1;
    bit          alu_hang = 0;
    bit          alu_ovf = 0;
    bit          alu_busy = 0;
    int          alu_cnt = 0;
    int          pulses = 0;
    int          issue_cyc = 0;
    logic [3:0]  cap_cmd;
    logic [31:0] cap_op1, cap_op2, res;

    initial begin
        alu_done = 0;
        alu_overflow = 0;
        alu_result = '0;
        forever begin
            @(negedge c_clk);
            alu_done = 0;
            alu_overflow = 0;
            alu_result = '0;
            if (reset) begin
                alu_busy = 0;
            end else begin
                if (alu_busy && !alu_hang) begin
                    if (alu_cnt <= 1) begin
                        case (cap_cmd)
                            4'd1: res = cap_op1 + cap_op2;
                            4'd2: res = cap_op1 - cap_op2;
                            4'd5: res = cap_op1 << cap_op2[4:0];
                            4'd6: res = cap_op1 >> cap_op2[4:0];
                            default: res = '0;
                        endcase
                        alu_done = 1;
                        alu_overflow = alu_ovf;
                        alu_result = res;
                        alu_busy = 0;
                    end else begin
                        alu_cnt--;
                    end
                end
                if (alu_valid) begin
                    pulses++;
                    issue_cyc = cyc;
                    cap_cmd = alu_cmd;
                    cap_op1 = alu_op1;
                    cap_op2 = alu_op2;
                    alu_busy = 1;
                    alu_cnt = alu_lat;
                end
            end
        end
    end

    // Response log, one entry per port per cycle with a non-zero output.
    int          rq_port [$];
    logic [1:0]  rq_code [$];
    logic [31:0] rq_data [$];
    int          rq_cyc  [$];
    int          overlap = 0;

    initial begin
        forever begin
            int nz;
            @(negedge c_clk);
            nz = 0;
            for (int p = 0; p < 4; p++) begin
                if (resp_w[p] != 0 || data_w[p] != 0) begin
                    nz++;
                    rq_port.push_back(p + 1);
                    rq_code.push_back(resp_w[p]);
                    rq_data.push_back(data_w[p]);
                    rq_cyc.push_back(cyc);
                end
            end
            if (nz > 1) overlap++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        rq_port.delete();
        rq_code.delete();
        rq_data.delete();
        rq_cyc.delete();
        pulses = 0;
        overlap = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        run(2);
        reset = 0;
        alu_hang = 0;
        alu_ovf = 0;
        alu_lat = 1;
        clear_log();
    endtask

    task automatic send(input int p, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b);
        cmd_v[p] = c;
        dat_v[p] = a;
        tick();
        cmd_v[p] = 0;
        dat_v[p] = b;
        tick();
        dat_v[p] = 0;
    endtask

    task automatic chk_resp(input string tag, input int i, input int port,
                            input logic [1:0] code, input logic [31:0] data);
        if (rq_port.size() <= i) begin
            check({tag, "_missing"}, 64'(rq_port.size()), 64'(i + 1));
        end else begin
            check({tag, "_port"}, 64'(rq_port[i]), 64'(port));
            check({tag, "_code"}, 64'(rq_code[i]), 64'(code));
            check({tag, "_data"}, 64'(rq_data[i]), 64'(data));
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        check({tag, "_valid"}, 64'(alu_valid), 64'd0);
        check({tag, "_cmd"}, 64'(alu_cmd), 64'd0);
        check({tag, "_op1"}, 64'(alu_op1), 64'd0);
        check({tag, "_op2"}, 64'(alu_op2), 64'd0);
        for (int p = 0; p < 4; p++) begin
            check({tag, "_resp"}, 64'(resp_w[p]), 64'd0);
            check({tag, "_data"}, 64'(data_w[p]), 64'd0);
        end
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            cmd_v[p] = 0;
            dat_v[p] = 0;
        end

        // Reset state; inputs during reset are ignored.
        reset = 1;
        cmd_v[0] = 4'd1;
        dat_v[0] = 32'h55;
        run(2);
        chk_idle_outs("rst");
        cmd_v[0] = 0;
        dat_v[0] = 0;
        tick();
        reset = 0;
        clear_log();
        run(10);
        check("rst_noresp", 64'(rq_port.size()), 64'd0);
        check("rst_nopulse", 64'(pulses), 64'd0);

        // Single add on port 1, minimum latency.
        do_reset();
        t0 = cyc;
        send(0, 4'd1, 32'h1, 32'h01FF_FFFF);
        run(12);
        check("p1_issue_lat", 64'(issue_cyc - t0), 64'd3);
        check("p1_pulses", 64'(pulses), 64'd1);
        check("p1_op2", 64'(cap_op2), 64'h01FF_FFFF);
        check("p1_nresp", 64'(rq_port.size()), 64'd1);
        chk_resp("p1", 0, 1, 2'd1, 32'h0200_0000);
        if (rq_cyc.size() > 0)
            check("p1_resp_lat", 64'(rq_cyc[0] - t0), 64'd5);

        // All four ports at once: serialized in port order.
        do_reset();
        alu_lat = 2;
        for (int p = 0; p < 4; p++) begin
            cmd_v[p] = 4'd1;
            dat_v[p] = 32'(10 * (p + 1));
        end
        tick();
        for (int p = 0; p < 4; p++) begin
            cmd_v[p] = 0;
            dat_v[p] = 32'(p + 1);
        end
        tick();
        for (int p = 0; p < 4; p++) dat_v[p] = 0;
        run(40);
        check("all_pulses", 64'(pulses), 64'd4);
        check("all_nresp", 64'(rq_port.size()), 64'd4);
        check("all_overlap", 64'(overlap), 64'd0);
        chk_resp("all0", 0, 1, 2'd1, 32'd11);
        chk_resp("all1", 1, 2, 2'd1, 32'd22);
        chk_resp("all2", 2, 3, 2'd1, 32'd33);
        chk_resp("all3", 3, 4, 2'd1, 32'd44);

        // Invalid command on port 2: no ALU issue.
        do_reset();
        t0 = cyc;
        send(1, 4'd3, 32'hDEAD_BEEF, 32'h1234);
        run(10);
        check("inv_pulses", 64'(pulses), 64'd0);
        check("inv_nresp", 64'(rq_port.size()), 64'd1);
        chk_resp("inv", 0, 2, 2'd2, 32'd0);
        if (rq_cyc.size() > 0)
            check("inv_lat", 64'(rq_cyc[0] - t0), 64'd3);

        // Overflow on port 3.
        do_reset();
        alu_ovf = 1;
        send(2, 4'd1, 32'hFFFF_FFFF, 32'h1);
        run(12);
        check("ovf_pulses", 64'(pulses), 64'd1);
        check("ovf_nresp", 64'(rq_port.size()), 64'd1);
        chk_resp("ovf", 0, 3, 2'd2, 32'd0);

        // Round robin: after port 3, port 4 beats port 2.
        do_reset();
        send(2, 4'd2, 32'd100, 32'd1);
        run(10);
        cmd_v[1] = 4'd5;
        dat_v[1] = 32'd1;
        cmd_v[3] = 4'd6;
        dat_v[3] = 32'h80;
        tick();
        cmd_v[1] = 0;
        dat_v[1] = 32'd4;
        cmd_v[3] = 0;
        dat_v[3] = 32'd3;
        tick();
        dat_v[1] = 0;
        dat_v[3] = 0;
        run(20);
        check("rr_nresp", 64'(rq_port.size()), 64'd3);
        chk_resp("rr0", 0, 3, 2'd1, 32'd99);
        chk_resp("rr1", 1, 4, 2'd1, 32'h10);
        chk_resp("rr2", 2, 2, 2'd1, 32'd16);

        // Commands on a busy slot are ignored.
        do_reset();
        alu_lat = 3;
        cmd_v[0] = 4'd1;
        dat_v[0] = 32'd5;
        tick();
        cmd_v[0] = 4'd6;
        dat_v[0] = 32'd6;
        tick();
        cmd_v[0] = 4'd2;
        dat_v[0] = 32'd77;
        tick();
        cmd_v[0] = 0;
        dat_v[0] = 0;
        run(25);
        check("busy_pulses", 64'(pulses), 64'd1);
        check("busy_cmd", 64'(cap_cmd), 64'd1);
        check("busy_nresp", 64'(rq_port.size()), 64'd1);
        chk_resp("busy", 0, 1, 2'd1, 32'd11);

        // Reset while waiting on the ALU.
        do_reset();
        alu_hang = 1;
        send(0, 4'd1, 32'd7, 32'd8);
        run(3);
        reset = 1;
        tick();
        chk_idle_outs("rstw");
        reset = 0;
        alu_hang = 0;
        run(20);
        check("rstw_nresp", 64'(rq_port.size()), 64'd0);
        check("rstw_pulses", 64'(pulses), 64'd1);

`ifdef CALC1_SCHED_TIMEOUT_EN
        do_reset();
        alu_hang = 1;
        t0 = cyc;
        send(3, 4'd1, 32'd1, 32'd2);
        run(25);
        check("tmo_nresp", 64'(rq_port.size()), 64'd1);
        chk_resp("tmo", 0, 4, 2'd3, 32'd0);
        if (rq_cyc.size() > 0)
            check("tmo_lat", 64'(rq_cyc[0] - t0), 64'd20);
`else
        do_reset();
        alu_hang = 1;
        send(3, 4'd1, 32'd1, 32'd2);
        run(40);
        check("hang_nresp", 64'(rq_port.size()), 64'd0);
        check("hang_pulses", 64'(pulses), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
